// File: rtl/ff_mode_reg.sv
`default_nettype none
// ============================================================================
//  Module   : ff_mode_reg
//  Function : WIDTH-bit register bank with run-time selectable D/T/JK/SR
//             next-state, parallel load, change pulse, illegal-SR flag and
//             saturating error counter. Optional macro FF_TOGGLE_CNT_EN adds
//             a saturating bit-toggle counter output (toggle_cnt).
//  Revision : 1.0 - initial release
// ============================================================================
module ff_mode_reg #(
    parameter int                 WIDTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              en,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              err_clr,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qb,
    output logic              changed,
    output logic              sr_err,
    output logic [CNT_W-1:0]  err_cnt
`ifdef FF_TOGGLE_CNT_EN
    ,
    output logic [CNT_W-1:0]  toggle_cnt
`endif
);

    localparam logic [1:0]       c_MODE_D  = 2'd0;
    localparam logic [1:0]       c_MODE_T  = 2'd1;
    localparam logic [1:0]       c_MODE_JK = 2'd2;
    localparam logic [1:0]       c_MODE_SR = 2'd3;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [WIDTH-1:0] r_q;
    logic             r_changed;
    logic             r_sr_err;
    logic [CNT_W-1:0] r_err_cnt;

    logic [WIDTH-1:0] w_ab;
    logic [WIDTH-1:0] w_mode_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_illegal;

    assign w_ab = a & b;

    always_comb begin
        w_mode_next = r_q;
        case (mode)
            c_MODE_D:  w_mode_next = a;
            c_MODE_T:  w_mode_next = r_q ^ a;
            c_MODE_JK: w_mode_next = (a & ~r_q) | (~b & r_q);
            // Bits with S=R=1 keep their old value; the rest follow S/R.
            c_MODE_SR: w_mode_next = ((a | (r_q & ~b)) & ~w_ab) | (r_q & w_ab);
            default:   w_mode_next = r_q;
        endcase
    end

    always_comb begin
        w_q_next = r_q;
        if (load) begin
            w_q_next = load_val;
        end else if (en) begin
            w_q_next = w_mode_next;
        end
    end

    assign w_illegal = (mode == c_MODE_SR) && en && !load && (|w_ab);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= RESET_VAL;
            r_changed <= 1'b0;
            r_sr_err  <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_q       <= w_q_next;
            r_changed <= (w_q_next != r_q);
            // A new illegal condition beats a simultaneous clear.
            if (w_illegal) begin
                r_sr_err <= 1'b1;
            end else if (err_clr) begin
                r_sr_err <= 1'b0;
            end
            if (w_illegal && (r_err_cnt != c_CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign q       = r_q;
    assign qb      = ~r_q;
    assign changed = r_changed;
    assign sr_err  = r_sr_err;
    assign err_cnt = r_err_cnt;

`ifdef FF_TOGGLE_CNT_EN
    localparam int c_SUM_W = ((CNT_W > $clog2(WIDTH + 1)) ? CNT_W : $clog2(WIDTH + 1)) + 1;

    logic [CNT_W-1:0]   r_toggle_cnt;
    logic [WIDTH-1:0]   w_flip;
    logic [c_SUM_W-1:0] w_pop;
    logic [c_SUM_W-1:0] w_sum;

    assign w_flip = r_q ^ w_q_next;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + c_SUM_W'(w_flip[i]);
        end
    end

    assign w_sum = c_SUM_W'(r_toggle_cnt) + w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_toggle_cnt <= '0;
        end else if (w_sum > c_SUM_W'(c_CNT_MAX)) begin
            r_toggle_cnt <= c_CNT_MAX;
        end else begin
            r_toggle_cnt <= w_sum[CNT_W-1:0];
        end
    end

    assign toggle_cnt = r_toggle_cnt;
`else
    // Toggle counter not built: no extra state or output in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_ff_mode_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ff_mode_reg
//  Function : Directed self-checking bench for ff_mode_reg (WIDTH=4, CNT_W=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ff_mode_reg;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic       en;
    logic [3:0] a;
    logic [3:0] b;
    logic       load;
    logic [3:0] load_val;
    logic       err_clr;
    logic [3:0] q;
    logic [3:0] qb;
    logic       changed;
    logic       sr_err;
    logic [7:0] err_cnt;
`ifdef FF_TOGGLE_CNT_EN
    logic [7:0] toggle_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    ff_mode_reg #(
        .WIDTH     (4),
        .RESET_VAL (4'b0000),
        .CNT_W     (8)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .en         (en),
        .a          (a),
        .b          (b),
        .load       (load),
        .load_val   (load_val),
        .err_clr    (err_clr),
        .q          (q),
        .qb         (qb),
        .changed    (changed),
        .sr_err     (sr_err),
        .err_cnt    (err_cnt)
`ifdef FF_TOGGLE_CNT_EN
        ,
        .toggle_cnt (toggle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mode = 2'd0; en = 1'b0; a = '0; b = '0;
        load = 1'b0; load_val = '0; err_clr = 1'b0;

        step();
        check("rst_q",       32'(q),       32'h0);
        check("rst_qb",      32'(qb),      32'hf);
        check("rst_changed", 32'(changed), 32'h0);
        check("rst_sr_err",  32'(sr_err),  32'h0);
        check("rst_err_cnt", 32'(err_cnt), 32'h0);

        // D mode
        rst = 1'b0; mode = 2'd0; en = 1'b1; a = 4'b1010;
        step();
        check("d_q",       32'(q),       32'ha);
        check("d_qb",      32'(qb),      32'h5);
        check("d_changed", 32'(changed), 32'h1);
        step();
        check("d_noop_changed", 32'(changed), 32'h0);

        // T mode
        mode = 2'd1; a = 4'b0110;
        step();
        check("t_q",       32'(q),       32'hc);
        check("t_changed", 32'(changed), 32'h1);
        a = 4'b0000;
        step();
        check("t_hold_q",       32'(q),       32'hc);
        check("t_hold_changed", 32'(changed), 32'h0);

        // JK mode: hold / reset / set / toggle
        mode = 2'd2; a = 4'b0011; b = 4'b0101;
        step();
        check("jk_q",       32'(q),       32'hb);
        check("jk_changed", 32'(changed), 32'h1);
        en = 1'b0;
        step();
        check("en0_q",       32'(q),       32'hb);
        check("en0_changed", 32'(changed), 32'h0);

        // Illegal SR operands with en=0 must not flag
        mode = 2'd3; a = 4'b1001; b = 4'b1100;
        step();
        check("en0_sr_err", 32'(sr_err), 32'h0);

        // Illegal SR
        en = 1'b1;
        step();
        check("sr_q",       32'(q),       32'hb);
        check("sr_sr_err",  32'(sr_err),  32'h1);
        check("sr_err_cnt", 32'(err_cnt), 32'h1);
        for (int i = 0; i < 253; i++) step();
        check("sr_cnt_254", 32'(err_cnt), 32'd254);
        step();
        check("sr_cnt_255", 32'(err_cnt), 32'd255);
        for (int i = 0; i < 45; i++) step();
        check("sr_cnt_sat", 32'(err_cnt), 32'd255);

        // err_clr alone clears only the flag
        err_clr = 1'b1; a = 4'b0000; b = 4'b0000;
        step();
        check("clr_sr_err",  32'(sr_err),  32'h0);
        check("clr_err_cnt", 32'(err_cnt), 32'd255);
        check("clr_q",       32'(q),       32'hb);

        // Set wins over clear
        a = 4'b1001; b = 4'b1100;
        step();
        check("setwin_sr_err", 32'(sr_err), 32'h1);
        a = 4'b0000; b = 4'b0000;
        step();
        check("setwin_clr", 32'(sr_err), 32'h0);

        // Load overrides en and SR checking
        err_clr = 1'b0; load = 1'b1; load_val = 4'b0101; a = 4'b1001; b = 4'b1100;
        step();
        check("load_q",       32'(q),       32'h5);
        check("load_changed", 32'(changed), 32'h1);
        check("load_sr_err",  32'(sr_err),  32'h0);
        check("load_err_cnt", 32'(err_cnt), 32'd255);

        // Reset overrides load and illegal SR
        rst = 1'b1;
        step();
        check("prio_rst_q",       32'(q),       32'h0);
        check("prio_rst_qb",      32'(qb),      32'hf);
        check("prio_rst_err_cnt", 32'(err_cnt), 32'h0);
        check("prio_rst_changed", 32'(changed), 32'h0);
        check("prio_rst_sr_err",  32'(sr_err),  32'h0);

        rst = 1'b0; load = 1'b0; mode = 2'd0; en = 1'b1; a = 4'b0000; b = 4'b0000;
        step();
        check("d_same_changed", 32'(changed), 32'h0);

`ifdef FF_TOGGLE_CNT_EN
        rst = 1'b1;
        step();
        check("tgl_rst", 32'(toggle_cnt), 32'd0);
        rst = 1'b0; a = 4'b1111;
        step();
        check("tgl_4", 32'(toggle_cnt), 32'd4);
        a = 4'b0000;
        step();
        check("tgl_8", 32'(toggle_cnt), 32'd8);
        a = 4'b0001;
        step();
        check("tgl_9", 32'(toggle_cnt), 32'd9);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
